// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared FSM state type, default panel timing and raster-size helpers
package lcd_timing_pkg;

    typedef enum logic [1:0] {ALIGN, RUN, FLUSH} lcd_state_e;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_SYNC   = 1;
    localparam int DEF_H_BACK   = 68;
    localparam int DEF_H_ACTIVE = 960;
    localparam int DEF_H_FRONT  = 91;
    localparam int DEF_V_SYNC   = 1;
    localparam int DEF_V_BACK   = 18;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FRONT  = 3;

    function automatic int total_of(input int sync, input int back, input int active, input int front);
        return sync + back + active + front;
    endfunction

    // one spare bit so end-of-window bounds (== total) stay representable
    function automatic int width_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lcd_dot_counter.sv
// lcd_dot_counter: free-running dot divider and h/v raster counters
//   clk, reset_n        : clock, async active-low reset
//   bnd_o               : last clk cycle of the current dot
//   dclk_next_o         : dot-clock level for the next clk cycle
//   h_next_o, v_next_o  : coordinates of the dot following the boundary
//   den_next_o          : next dot lies in the active window
//   is_fad_next_o       : next dot is the first active dot of the frame
//   is_lad_next_o       : next dot is the last active dot of the frame
//   is_lad_cur_o        : current dot is the last active dot of the frame
module lcd_dot_counter
    import lcd_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    localparam int H_TOTAL = total_of(H_SYNC, H_BACK, H_ACTIVE, H_FRONT),
    localparam int V_TOTAL = total_of(V_SYNC, V_BACK, V_ACTIVE, V_FRONT),
    localparam int HW      = width_of(H_TOTAL),
    localparam int VW      = width_of(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          bnd_o,
    output logic          dclk_next_o,
    output logic [HW-1:0] h_next_o,
    output logic [VW-1:0] v_next_o,
    output logic          den_next_o,
    output logic          is_fad_next_o,
    output logic          is_lad_next_o,
    output logic          is_lad_cur_o
);
    localparam int DW = width_of(2 * CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_DEN_B  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_DEN_E  = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [HW-1:0] H_LAD    = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_DEN_B  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_DEN_E  = VW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [VW-1:0] V_LAD    = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    always_comb begin
        bnd_o         = div_q == DIV_LAST;
        div_d         = bnd_o ? '0 : div_q + DW'(1);
        h_next_o      = (h_q == H_LAST) ? '0 : h_q + HW'(1);
        v_next_o      = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + VW'(1);
        dclk_next_o   = div_d >= DIV_HALF;
        den_next_o    = h_next_o >= H_DEN_B && h_next_o < H_DEN_E && v_next_o >= V_DEN_B && v_next_o < V_DEN_E;
        is_fad_next_o = h_next_o == H_DEN_B && v_next_o == V_DEN_B;
        is_lad_next_o = h_next_o == H_LAD && v_next_o == V_LAD;
        is_lad_cur_o  = h_q == H_LAD && v_q == V_LAD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            if (bnd_o) begin
                h_q <= h_next_o;
                v_q <= v_next_o;
            end
        end
    end

endmodule

// File: rtl/lcd_stream_timing_gen.sv
// lcd_stream_timing_gen: serial-RGB LCD raster generator fed by an 8-bit Avalon-ST byte stream
//   clk, reset_n                 : clock, async active-low reset
//   in_ready/in_valid/in_data    : byte stream handshake, one byte per active dot
//   in_startofpacket/endofpacket : frame delimiters, checked against FAD/LAD
//   clear_status                 : pulse clearing the sticky flags
//   lcd_dclk/hsync_n/vsync_n/den : panel timing, registered
//   lcd_data                     : panel byte, zero outside den or while not in sync
//   underflow, sync_err          : sticky error flags
module lcd_stream_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       clear_status,
    output logic       lcd_dclk,
    output logic       lcd_hsync_n,
    output logic       lcd_vsync_n,
    output logic       lcd_den,
    output logic [7:0] lcd_data,
    output logic       underflow,
    output logic       sync_err
);
    localparam int HW = width_of(total_of(H_SYNC, H_BACK, H_ACTIVE, H_FRONT));
    localparam int VW = width_of(total_of(V_SYNC, V_BACK, V_ACTIVE, V_FRONT));
    localparam logic [1:0] ST_ALIGN = ALIGN;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    logic          bnd, dclk_next, den_next, is_fad_next, is_lad_next, is_lad_cur;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic [1:0]    state_q, state_d;
    logic          dclk_q, hsync_n_q, vsync_n_q, den_q, uf_q, uf_d, se_q, se_d;
    logic [7:0]    data_q, data_d;
    logic          xfer, run_dot, uf_set, se_set;

    lcd_dot_counter #(
        .CLK_DIV (CLK_DIV),
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACTIVE(H_ACTIVE),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE),
        .V_FRONT (V_FRONT)
    ) u_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .bnd_o        (bnd),
        .dclk_next_o  (dclk_next),
        .h_next_o     (h_next),
        .v_next_o     (v_next),
        .den_next_o   (den_next),
        .is_fad_next_o(is_fad_next),
        .is_lad_next_o(is_lad_next),
        .is_lad_cur_o (is_lad_cur)
    );

    always_comb begin
        // ALIGN swallows non-SOP bytes at any time but parks an SOP until the FAD boundary
        in_ready = reset_n && ((state_q == ST_ALIGN) ? in_valid && (!in_startofpacket || (bnd && is_fad_next))
                                                     : (state_q == ST_RUN) && bnd && den_next);
        xfer     = in_ready && in_valid;
        run_dot  = (state_q == ST_RUN) && bnd && den_next;
        uf_set   = run_dot && !in_valid;
        se_set   = run_dot && in_valid && ((in_startofpacket && !is_fad_next) || (in_endofpacket != is_lad_next));
        // discarded ALIGN bytes never reach the panel; only RUN bytes or the aligning SOP do
        data_d   = (xfer && (state_q == ST_RUN || in_startofpacket)) ? in_data : 8'h00;
        uf_d     = uf_set || (uf_q && !clear_status);
        se_d     = se_set || (se_q && !clear_status);
        state_d  = (state_q == ST_ALIGN && xfer && in_startofpacket) ? ST_RUN
                 : (uf_set || se_set) ? ST_FLUSH
                 : (state_q == ST_FLUSH && bnd && is_lad_cur) ? ST_ALIGN
                 : state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ALIGN;
            dclk_q    <= 1'b0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            den_q     <= 1'b0;
            data_q    <= 8'h00;
            uf_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            dclk_q  <= dclk_next;
            uf_q    <= uf_d;
            se_q    <= se_d;
            if (bnd) begin
                hsync_n_q <= h_next >= HW'(H_SYNC);
                vsync_n_q <= v_next >= VW'(V_SYNC);
                den_q     <= den_next;
                data_q    <= data_d;
            end
        end
    end

    assign lcd_dclk    = dclk_q;
    assign lcd_hsync_n = hsync_n_q;
    assign lcd_vsync_n = vsync_n_q;
    assign lcd_den     = den_q;
    assign lcd_data    = data_q;
    assign underflow   = uf_q;
    assign sync_err    = se_q;

endmodule

// File: tb/tb_lcd_stream_timing_gen.sv
// tb_lcd_stream_timing_gen: directed bench for the LCD timing generator on a 6x5-dot raster
module tb_lcd_stream_timing_gen;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_startofpacket = 1'b0;
    logic       in_endofpacket = 1'b0;
    logic       clear_status = 1'b0;
    logic       lcd_dclk, lcd_hsync_n, lcd_vsync_n, lcd_den;
    logic [7:0] lcd_data;
    logic       underflow, sync_err;

    always #5 clk = ~clk;

    lcd_stream_timing_gen #(
        .CLK_DIV(2), .H_SYNC(1), .H_BACK(1), .H_ACTIVE(3), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_ready        (in_ready),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_startofpacket(in_startofpacket),
        .in_endofpacket  (in_endofpacket),
        .clear_status    (clear_status),
        .lcd_dclk        (lcd_dclk),
        .lcd_hsync_n     (lcd_hsync_n),
        .lcd_vsync_n     (lcd_vsync_n),
        .lcd_den         (lcd_den),
        .lcd_data        (lcd_data),
        .underflow       (underflow),
        .sync_err        (sync_err)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ncyc = 0;
    int         cur = 0;
    logic       rdy_chk = 1'b0;
    logic [9:0] q[$];
    logic [7:0] exp_d [0:127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic e);
        q.push_back({s, e, d});
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < 6; i++) push(base + 8'(i), i == 0, i == 5);
    endtask

    task automatic set_frame(input int f, input logic [7:0] base);
        for (int k = 0; k < 3; k++) begin
            exp_d[30 * f + 14 + k] = base + 8'(k);
            exp_d[30 * f + 20 + k] = base + 8'(k + 3);
        end
    endtask

    // one clk cycle: source pops on a handshake seen at the previous negedge, presents the next byte after the edge
    task automatic tick();
        logic x;
        x = in_ready && in_valid;
        @(posedge clk);
        #1;
        if (x) void'(q.pop_front());
        if (q.size() > 0) begin
            in_valid = 1'b1;
            {in_startofpacket, in_endofpacket, in_data} = q[0];
        end else begin
            in_valid = 1'b0;
            {in_startofpacket, in_endofpacket, in_data} = 10'd0;
        end
        @(negedge clk);
        ncyc++;
    endtask

    task automatic check_dot(input int n);
        int h, v;
        h = n % 6;
        v = (n / 6) % 5;
        chk($sformatf("d%0d_dclk", n), lcd_dclk, 1'b0);
        chk($sformatf("d%0d_hs", n), lcd_hsync_n, h != 0);
        chk($sformatf("d%0d_vs", n), lcd_vsync_n, v != 0);
        chk($sformatf("d%0d_den", n), lcd_den, h >= 2 && h <= 4 && v >= 2 && v <= 3);
        chk($sformatf("d%0d_data", n), lcd_data, exp_d[n]);
        if (rdy_chk) chk($sformatf("d%0d_rdy", n), in_ready, 1'b0);
    endtask

    task automatic run_to(input int t);
        for (int n = cur + 1; n <= t; n++) begin
            while (ncyc < 4 * n) tick();
            check_dot(n);
        end
        cur = t;
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        clear_status = 1'b0;
        q.delete();
        in_valid = 1'b1;
        in_data = 8'h5A;
        in_startofpacket = 1'b0;
        in_endofpacket = 1'b0;
        #1;
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_dclk", lcd_dclk, 1'b0);
        chk("rst_hs", lcd_hsync_n, 1'b1);
        chk("rst_vs", lcd_vsync_n, 1'b1);
        chk("rst_den", lcd_den, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_uf", underflow, 1'b0);
        chk("rst_se", sync_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'h00;
        reset_n = 1'b1;
        ncyc = 0;
        cur = 0;
        foreach (exp_d[i]) exp_d[i] = 8'h00;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    initial begin
        #2;
        // idle raster, no stream
        do_reset();
        rdy_chk = 1'b1;
        run_to(35);
        rdy_chk = 1'b0;
        tick();
        tick();
        chk("s1_dclk_hi", lcd_dclk, 1'b1);
        chk("s1_uf", underflow, 1'b0);

        // three back-to-back frames
        do_reset();
        for (int f = 0; f < 3; f++) begin
            push_frame(8'h01);
            set_frame(f, 8'h01);
        end
        run_to(90);
        chk("s2_uf", underflow, 1'b0);
        chk("s2_se", sync_err, 1'b0);

        // junk ahead of the first SOP
        do_reset();
        push(8'hAA, 1'b0, 1'b0);
        push(8'hBB, 1'b0, 1'b0);
        push_frame(8'h01);
        set_frame(0, 8'h01);
        run_to(5);
        chk("s3_junk_drop", q.size(), 6);
        run_to(29);
        chk("s3_uf", underflow, 1'b0);
        chk("s3_se", sync_err, 1'b0);

        // underflow before byte 4, realign next frame, clear
        do_reset();
        push(8'h01, 1'b1, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        exp_d[14] = 8'h01;
        exp_d[15] = 8'h02;
        exp_d[16] = 8'h03;
        run_to(19);
        chk("s4_uf_pre", underflow, 1'b0);
        run_to(20);
        chk("s4_uf_set", underflow, 1'b1);
        run_to(21);
        push_frame(8'h01);
        set_frame(1, 8'h01);
        run_to(53);
        chk("s4_uf_sticky", underflow, 1'b1);
        chk("s4_se", sync_err, 1'b0);
        pulse_clear();
        chk("s4_uf_clr", underflow, 1'b0);

        // early EOP, recovery, clear vs coincident new error
        do_reset();
        push(8'h01, 1'b1, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b1);
        push(8'h04, 1'b0, 1'b0);
        push(8'h05, 1'b0, 1'b0);
        push(8'h06, 1'b0, 1'b1);
        push_frame(8'h11);
        push(8'h21, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b0);
        exp_d[14] = 8'h01;
        exp_d[15] = 8'h02;
        exp_d[16] = 8'h03;
        set_frame(1, 8'h11);
        exp_d[74] = 8'h21;
        exp_d[75] = 8'h22;
        run_to(15);
        chk("s5_se_pre", sync_err, 1'b0);
        run_to(16);
        chk("s5_se_eop", sync_err, 1'b1);
        run_to(60);
        pulse_clear();
        chk("s5_se_clr", sync_err, 1'b0);
        run_to(74);
        chk("s5_se_fad", sync_err, 1'b0);
        while (ncyc < 299) tick();
        pulse_clear();
        run_to(75);
        chk("s5_se_wins", sync_err, 1'b1);
        run_to(85);
        chk("s5_se_end", sync_err, 1'b1);
        chk("s5_uf", underflow, 1'b0);

        // reset mid active line, then idle restart
        do_reset();
        push_frame(8'h01);
        set_frame(0, 8'h01);
        run_to(15);
        tick();
        tick();
        chk("s6_dclk_mid", lcd_dclk, 1'b1);
        chk("s6_den_mid", lcd_den, 1'b1);
        do_reset();
        rdy_chk = 1'b1;
        run_to(35);
        rdy_chk = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
